// File: rtl/cond_directive_filter_pkg.sv
// rtl/cond_directive_filter_pkg.sv - token kinds, error codes, FSM states and stack entry layout
package cond_directive_filter_pkg;

  typedef enum logic [2:0] {
    K_TEXT   = 3'd0,
    K_IFDEF  = 3'd1,
    K_IFNDEF = 3'd2,
    K_ELSIF  = 3'd3,
    K_ELSE   = 3'd4,
    K_ENDIF  = 3'd5,
    K_RSV6   = 3'd6,
    K_RSV7   = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    E_NONE             = 3'd0,
    E_UNMATCHED        = 3'd1,
    E_ELSIF_AFTER_ELSE = 3'd2,
    E_DOUBLE_ELSE      = 3'd3,
    E_OVERFLOW         = 3'd4,
    E_UNTERMINATED     = 3'd5
  } err_e;

  typedef enum logic {
    S_RUN = 1'b0,
    S_ERR = 1'b1
  } state_e;

  typedef struct packed {
    logic parent_active;
    logic taken;
    logic seen_else;
    logic branch_active;
  } stack_entry_t;

endpackage

// File: rtl/cond_directive_filter_if.sv
// rtl/cond_directive_filter_if.sv - token input stream and filtered output stream
interface cond_directive_filter_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic              in_defined;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_empty;

  modport master (
    output in_valid, in_kind, in_defined, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_empty
  );

  modport slave (
    input  in_valid, in_kind, in_defined, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_empty
  );
endinterface

// File: rtl/cond_directive_filter_stack.sv
// rtl/cond_directive_filter_stack.sv - conditional nesting LIFO (module cond_stack)
// Push and top-update are mutually exclusive; clear wins over everything.
module cond_stack
  import cond_directive_filter_pkg::*;
#(
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  stack_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_upd,
  input  stack_entry_t       i_upd_entry,
  output stack_entry_t       o_top,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_W-1:0] o_depth
);

  localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  stack_entry_t       r_mem [MAX_DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic [IDX_W-1:0]   w_top_idx;
  logic [IDX_W-1:0]   w_push_idx;

  assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));
  assign w_push_idx = IDX_W'(r_depth);
  assign o_empty    = (r_depth == '0);
  assign o_full     = (r_depth == DEPTH_W'(MAX_DEPTH));
  assign o_depth    = r_depth;
  assign o_top      = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_depth <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_depth <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[w_push_idx] <= i_push_entry;
        r_depth           <= r_depth + DEPTH_W'(1);
      end else if (i_pop && !o_empty) begin
        r_depth <= r_depth - DEPTH_W'(1);
      end
      if (i_upd && !o_empty) begin
        r_mem[w_top_idx] <= i_upd_entry;
      end
    end
  end

endmodule

// File: rtl/cond_directive_filter.sv
// rtl/cond_directive_filter.sv - streaming `ifdef/`else/`endif evaluator forwarding active TEXT tokens
// Token decode, RUN/ERR FSM, one-entry output register and error reporting.
module cond_directive_filter
  import cond_directive_filter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  cond_directive_filter_if.slave io_bus,
  output logic                   o_err_valid,
  output logic [2:0]             o_err_code,
  output logic                   o_err_sticky,
  output logic [DEPTH_W-1:0]     o_depth
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic               r_out_empty;
  logic               r_err_valid;
  logic [2:0]         r_err_code;
  logic               r_err_sticky;

  logic               w_accept;
  kind_e              w_kind;
  logic               w_active;
  logic               w_cond;
  logic               w_text_hit;
  err_e               w_err;
  logic               w_emit;
  logic [DATA_W-1:0]  w_emit_data;
  logic               w_emit_last;
  logic               w_emit_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_upd;
  logic               w_clear;
  stack_entry_t       w_push_entry;
  stack_entry_t       w_upd_entry;
  stack_entry_t       w_top;
  logic               w_full;
  logic               w_empty;
  logic [DEPTH_W-1:0] w_depth;
  logic [DEPTH_W-1:0] w_depth_after;

  cond_stack #(
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W)
  ) u_stack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_push_entry(w_push_entry),
    .i_pop       (w_pop),
    .i_upd       (w_upd),
    .i_upd_entry (w_upd_entry),
    .o_top       (w_top),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_depth     (w_depth)
  );

  assign io_bus.in_ready  = !r_out_valid || io_bus.out_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.out_empty = r_out_empty;
  assign o_err_valid      = r_err_valid;
  assign o_err_code       = r_err_code;
  assign o_err_sticky     = r_err_sticky;
  assign o_depth          = w_depth;

  assign w_accept = io_bus.in_valid && io_bus.in_ready;
  assign w_kind   = kind_e'(io_bus.in_kind);
  assign w_active = w_empty ? 1'b1 : w_top.branch_active;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cond        = 1'b0;
    w_text_hit    = 1'b0;
    w_err         = E_NONE;
    w_emit        = 1'b0;
    w_emit_data   = '0;
    w_emit_last   = 1'b0;
    w_emit_empty  = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_upd         = 1'b0;
    w_clear       = 1'b0;
    w_push_entry  = '0;
    w_upd_entry   = w_top;
    w_depth_after = w_depth;

    if (w_accept && r_state == S_RUN) begin
      case (w_kind)
        K_IFDEF, K_IFNDEF: begin
          w_cond = (w_kind == K_IFDEF) ? io_bus.in_defined : !io_bus.in_defined;
          if (w_full) begin
            w_err = E_OVERFLOW;
          end else begin
            w_push                     = 1'b1;
            w_push_entry.parent_active = w_active;
            w_push_entry.taken         = w_cond;
            w_push_entry.seen_else     = 1'b0;
            w_push_entry.branch_active = w_active && w_cond;
            w_depth_after              = w_depth + DEPTH_W'(1);
          end
        end
        K_ELSIF: begin
          if (w_empty) begin
            w_err = E_UNMATCHED;
          end else if (w_top.seen_else) begin
            w_err = E_ELSIF_AFTER_ELSE;
          end else begin
            w_upd                     = 1'b1;
            w_upd_entry.branch_active = w_top.parent_active && !w_top.taken && io_bus.in_defined;
            w_upd_entry.taken         = w_top.taken || io_bus.in_defined;
          end
        end
        K_ELSE: begin
          if (w_empty) begin
            w_err = E_UNMATCHED;
          end else if (w_top.seen_else) begin
            w_err = E_DOUBLE_ELSE;
          end else begin
            w_upd                     = 1'b1;
            w_upd_entry.branch_active = w_top.parent_active && !w_top.taken;
            w_upd_entry.taken         = 1'b1;
            w_upd_entry.seen_else     = 1'b1;
          end
        end
        K_ENDIF: begin
          if (w_empty) begin
            w_err = E_UNMATCHED;
          end else begin
            w_pop         = 1'b1;
            w_depth_after = w_depth - DEPTH_W'(1);
          end
        end
        default: w_text_hit = w_active;
      endcase

      if (w_err != E_NONE) begin
        w_state_nxt = S_ERR;
      end

      // The final token always closes the file: the FSM returns to RUN with an empty stack.
      if (io_bus.in_last) begin
        w_emit       = 1'b1;
        w_emit_last  = 1'b1;
        w_emit_data  = w_text_hit ? io_bus.in_data : '0;
        w_emit_empty = !w_text_hit;
        w_clear      = 1'b1;
        w_state_nxt  = S_RUN;
        if (w_err == E_NONE && w_depth_after != '0) begin
          w_err = E_UNTERMINATED;
        end
      end else if (w_text_hit) begin
        w_emit      = 1'b1;
        w_emit_data = io_bus.in_data;
      end
    end else if (w_accept && io_bus.in_last) begin
      w_emit       = 1'b1;
      w_emit_last  = 1'b1;
      w_emit_empty = 1'b1;
      w_clear      = 1'b1;
      w_state_nxt  = S_RUN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_empty  <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_emit_data;
        r_out_last  <= w_emit_last;
        r_out_empty <= w_emit_empty;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_last  <= 1'b0;
        r_out_empty <= 1'b0;
      end
      r_err_valid <= (w_err != E_NONE);
      if (w_err != E_NONE) begin
        r_err_code   <= w_err;
        r_err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_directive_filter.sv
// tb/tb_cond_directive_filter.sv - vector table, directed corner cases and randomized files against a model
module tb_cond_directive_filter;
  localparam int DATA_W    = 8;
  localparam int MAX_DEPTH = 8;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               err_valid;
  logic [2:0]         err_code;
  logic               err_sticky;
  logic [DEPTH_W-1:0] depth;

  cond_directive_filter_if #(.DATA_W(DATA_W)) bus();

  cond_directive_filter #(
    .DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH), .DEPTH_W(DEPTH_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus),
    .o_err_valid(err_valid), .o_err_code(err_code),
    .o_err_sticky(err_sticky), .o_depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    logic       def;
    logic [7:0] data;
    logic       last;
  } tok_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       empty;
  } beat_t;

  typedef struct {
    tok_t       t;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_empty;
    logic [2:0] e_err;
    logic [3:0] e_depth;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  int    rdy_mode = 0;
  beat_t got_beats[$];
  beat_t exp_beats[$];
  int    got_errs[$];
  int    exp_errs[$];
  vec_t  vt[$];
  tok_t  toks[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid && bus.out_ready)
          got_beats.push_back('{bus.out_data, bus.out_last, bus.out_empty});
        if (err_valid) got_errs.push_back(int'(err_code));
      end
    end
  end

  function automatic tok_t mk(input int kind, input int def, input int data, input int last);
    tok_t t;
    t.kind = 3'(kind); t.def = 1'(def); t.data = 8'(data); t.last = 1'(last);
    return t;
  endfunction

  task automatic addv(input int k, input int d, input int dat, input int l,
                      input int ev, input int ed, input int el, input int ee,
                      input int er, input int dep);
    vec_t v;
    v.t = mk(k, d, dat, l);
    v.e_valid = 1'(ev); v.e_data = 8'(ed); v.e_last = 1'(el); v.e_empty = 1'(ee);
    v.e_err = 3'(er); v.e_depth = 4'(dep);
    vt.push_back(v);
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input tok_t t);
    int n = 0;
    bus.in_kind = t.kind; bus.in_defined = t.def; bus.in_data = t.data; bus.in_last = t.last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck at 0");
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    repeat (3) @(negedge clk);
    while (bus.out_valid && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: out_valid never cleared");
    end
  endtask

  // Reference: a branch is live when every enclosing conditional has selected it.
  task automatic model_file(input tok_t ts[$]);
    bit sel_q[$]; bit taken_q[$]; bit else_q[$];
    bit err_mode = 0;
    exp_beats.delete(); exp_errs.delete();
    foreach (ts[i]) begin
      tok_t t = ts[i];
      int   err = 0;
      bit   hit = 0;
      bit   act = 1;
      bit   c;
      if (err_mode) begin
        if (t.last) begin
          exp_beats.push_back('{8'h00, 1'b1, 1'b1});
          err_mode = 0; sel_q.delete(); taken_q.delete(); else_q.delete();
        end
        continue;
      end
      foreach (sel_q[j]) act = act & sel_q[j];
      case (t.kind)
        3'd1, 3'd2: begin
          c = (t.kind == 3'd1) ? t.def : !t.def;
          if (sel_q.size() == MAX_DEPTH) err = 4;
          else begin sel_q.push_back(c); taken_q.push_back(c); else_q.push_back(0); end
        end
        3'd3: begin
          if (sel_q.size() == 0) err = 1;
          else if (else_q[$]) err = 2;
          else begin
            sel_q[$] = !taken_q[$] && t.def;
            taken_q[$] = taken_q[$] || t.def;
          end
        end
        3'd4: begin
          if (sel_q.size() == 0) err = 1;
          else if (else_q[$]) err = 3;
          else begin sel_q[$] = !taken_q[$]; taken_q[$] = 1; else_q[$] = 1; end
        end
        3'd5: begin
          if (sel_q.size() == 0) err = 1;
          else begin void'(sel_q.pop_back()); void'(taken_q.pop_back()); void'(else_q.pop_back()); end
        end
        default: hit = act;
      endcase
      if (t.last) begin
        exp_beats.push_back('{hit ? t.data : 8'h00, 1'b1, !hit});
        if (err == 0 && sel_q.size() != 0) err = 5;
        sel_q.delete(); taken_q.delete(); else_q.delete();
      end else begin
        if (hit) exp_beats.push_back('{t.data, 1'b0, 1'b0});
        if (err != 0) err_mode = 1;
      end
      if (err != 0) exp_errs.push_back(err);
    end
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_beat_count"}, got_beats.size(), exp_beats.size());
    for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i),
            {got_beats[i].data, got_beats[i].last, got_beats[i].empty},
            {exp_beats[i].data, exp_beats[i].last, exp_beats[i].empty});
    check({tag, "_err_count"}, got_errs.size(), exp_errs.size());
    for (int i = 0; i < got_errs.size() && i < exp_errs.size(); i++)
      check($sformatf("%s_err%0d", tag, i), got_errs[i], exp_errs[i]);
  endtask

  initial begin
    bit any_err;
    bus.in_valid = 0; bus.in_kind = 0; bus.in_defined = 0; bus.in_data = 0; bus.in_last = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_depth", depth, 0);
    check("rst_err", {err_valid, err_code, err_sticky}, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // kind, def, data, last | valid, data, last, empty, err, depth
    addv(1,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h41,0, 1,8'h41,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h42,0, 0,8'h00,0,0, 0,1);
    addv(5,0,8'h00,1, 1,8'h00,1,1, 0,0);
    addv(1,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(3,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(3,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h33,0, 1,8'h33,0,0, 0,1);
    addv(3,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h44,0, 0,8'h00,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h55,0, 0,8'h00,0,0, 0,1);
    addv(5,0,8'h00,1, 1,8'h00,1,1, 0,0);
    addv(1,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(1,1,8'h00,0, 0,8'h00,0,0, 0,2);
    addv(0,0,8'h11,0, 0,8'h00,0,0, 0,2);
    addv(5,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(5,0,8'h00,1, 1,8'h00,1,1, 0,0);
    addv(1,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 3,1);
    addv(0,0,8'h99,0, 0,8'h00,0,0, 0,1);
    addv(5,0,8'h00,1, 1,8'h00,1,1, 0,0);
    addv(1,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(3,1,8'h00,0, 0,8'h00,0,0, 2,1);
    addv(0,0,8'h05,1, 1,8'h00,1,1, 0,0);
    addv(5,0,8'h00,1, 1,8'h00,1,1, 1,0);
    addv(6,0,8'h66,0, 1,8'h66,0,0, 0,0);
    addv(3,1,8'h00,0, 0,8'h00,0,0, 1,0);
    addv(0,0,8'h77,1, 1,8'h00,1,1, 0,0);
    addv(2,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h5A,1, 1,8'h5A,1,0, 5,0);
    addv(2,1,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(0,0,8'h22,0, 0,8'h00,0,0, 0,1);
    addv(4,0,8'h00,0, 0,8'h00,0,0, 0,1);
    addv(7,0,8'h23,1, 1,8'h23,1,0, 5,0);

    foreach (vt[i]) begin
      send(vt[i].t);
      check($sformatf("v%0d_out_valid", i), bus.out_valid, vt[i].e_valid);
      if (vt[i].e_valid)
        check($sformatf("v%0d_beat", i), {bus.out_data, bus.out_last, bus.out_empty},
              {vt[i].e_data, vt[i].e_last, vt[i].e_empty});
      check($sformatf("v%0d_err_valid", i), err_valid, vt[i].e_err != 0);
      if (vt[i].e_err != 0) check($sformatf("v%0d_err_code", i), err_code, vt[i].e_err);
      check($sformatf("v%0d_depth", i), depth, vt[i].e_depth);
    end

    // Overflow, then recovery on the next last token.
    drain();
    got_beats.delete(); got_errs.delete();
    @(posedge clk); #2;
    for (int i = 0; i <= MAX_DEPTH; i++) send(mk(1, 1, 0, 0));
    check("ovf_err", {err_valid, err_code}, {1'b1, 3'd4});
    check("ovf_sticky", err_sticky, 1);
    check("ovf_depth", depth, MAX_DEPTH);
    send(mk(0, 0, 8'h12, 0));
    send(mk(5, 0, 0, 0));
    check("ovf_frozen_depth", depth, MAX_DEPTH);
    send(mk(0, 0, 8'h34, 1));
    check("ovf_end_depth", depth, 0);
    send(mk(1, 1, 0, 0));
    send(mk(0, 0, 8'h56, 0));
    send(mk(5, 0, 0, 1));
    drain();
    exp_beats = '{'{8'h00, 1'b1, 1'b1}, '{8'h56, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b1}};
    exp_errs  = '{4};
    compare_queues("ovf");

    // Stalled sink holds the last beat.
    got_beats.delete(); got_errs.delete();
    @(posedge clk); #2;
    rdy_mode = 2;
    @(posedge clk); #2;
    send(mk(1, 1, 0, 0));
    send(mk(0, 0, 8'h7E, 1));
    check("bp_err", {err_valid, err_code}, {1'b1, 3'd5});
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k),
            {bus.out_valid, bus.out_data, bus.out_last, bus.in_ready},
            {1'b1, 8'h7E, 1'b1, 1'b0});
      @(posedge clk); #2;
    end
    rdy_mode = 0;
    drain();
    exp_beats = '{'{8'h7E, 1'b1, 1'b0}};
    exp_errs  = '{5};
    compare_queues("bp");

    // Reset with a pending beat and an open conditional.
    rdy_mode = 2;
    @(posedge clk); #2;
    send(mk(1, 1, 0, 0));
    send(mk(0, 0, 8'h10, 0));
    check("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("mid_rst_out", {bus.out_valid, bus.out_data, bus.out_last, bus.out_empty}, 0);
    check("mid_rst_err", {err_valid, err_code, err_sticky}, 0);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    rdy_mode = 1;

    any_err = 0;
    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(1, 14);
      toks.delete();
      for (int j = 0; j < len; j++) begin
        int r = $urandom_range(0, 99);
        int k;
        if (r < 40)      k = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : 0;
        else if (r < 55) k = 1;
        else if (r < 65) k = 2;
        else if (r < 75) k = 3;
        else if (r < 83) k = 4;
        else             k = 5;
        toks.push_back(mk(k, $urandom_range(0, 1), $urandom_range(0, 255), j == len - 1));
      end
      model_file(toks);
      got_beats.delete(); got_errs.delete();
      @(posedge clk); #2;
      foreach (toks[j]) begin
        if ($urandom_range(0, 4) == 0) begin @(posedge clk); #2; end
        send(toks[j]);
      end
      drain();
      compare_queues($sformatf("rnd%0d", f));
      if (exp_errs.size() != 0) any_err = 1;
      check($sformatf("rnd%0d_depth", f), depth, 0);
      check($sformatf("rnd%0d_sticky", f), err_sticky, any_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
